// File: rtl/full_subtractor_if.sv
// Bundles the operand, result and valid signals of full_subtractor.
// Ports (slave = DUT side):
//   a, b, borrow_in, in_valid           inputs to the subtractor
//   diff, borrow_out                    combinational result
//   diff_q, borrow_out_q, out_valid     registered result and its valid flag
interface full_subtractor_if #(
    parameter int unsigned WIDTH = 1
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             in_valid;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_out_q;
    logic             out_valid;

    modport master (
        output a, b, borrow_in, in_valid,
        input  diff, borrow_out, diff_q, borrow_out_q, out_valid
    );

    modport slave (
        input  a, b, borrow_in, in_valid,
        output diff, borrow_out, diff_q, borrow_out_q, out_valid
    );
endinterface

// File: rtl/full_subtractor.sv
// Structural ripple-borrow subtractor: computes a - b - borrow_in.
// Ports:
//   clk   rising-edge clock, used only by the registered copy
//   rst   synchronous active-high reset of the registered copy
//   bus   full_subtractor_if.slave:
//         a, b (WIDTH), borrow_in, in_valid in;
//         diff (WIDTH), borrow_out combinational out;
//         diff_q (WIDTH), borrow_out_q, out_valid registered out (1-cycle latency)
module full_subtractor #(
    parameter int unsigned WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    full_subtractor_if.slave     bus
);

    // Borrow chain: entry 0 is the external borrow, entry WIDTH leaves the MSB.
    logic [WIDTH:0]   bin_chain;
    logic [WIDTH-1:0] diff_c;

    assign bin_chain[0] = bus.borrow_in;

    // One full-subtractor cell per bit: two half subtractors and an OR.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic d1;
        logic b1;
        logic b2;

        assign d1               = bus.a[i] ^ bus.b[i];
        assign b1               = ~bus.a[i] & bus.b[i];
        assign diff_c[i]        = d1 ^ bin_chain[i];
        assign b2               = ~d1 & bin_chain[i];
        assign bin_chain[i + 1] = b1 | b2;
    end

    // Combinational result, independent of clk/rst.
    assign bus.diff       = diff_c;
    assign bus.borrow_out = bin_chain[WIDTH];

    logic [WIDTH-1:0] res_diff_q;
    logic [WIDTH-1:0] res_diff_d;
    logic             res_borrow_q;
    logic             res_borrow_d;
    logic             out_valid_q;
    logic             out_valid_d;

    // Capture the result only on qualified inputs; otherwise hold.
    always_comb begin
        res_diff_d   = res_diff_q;
        res_borrow_d = res_borrow_q;
        out_valid_d  = bus.in_valid;
        if (bus.in_valid) begin
            res_diff_d   = diff_c;
            res_borrow_d = bin_chain[WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_diff_q   <= '0;
            res_borrow_q <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            res_diff_q   <= res_diff_d;
            res_borrow_q <= res_borrow_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign bus.diff_q       = res_diff_q;
    assign bus.borrow_out_q = res_borrow_q;
    assign bus.out_valid    = out_valid_q;

endmodule

// File: tb/tb_full_subtractor.sv
// Self-checking bench for full_subtractor at WIDTH=1 and WIDTH=4.
module tb_full_subtractor;

    logic clk = 1'b0;
    logic clk_run = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 if (clk_run) clk = ~clk;

    full_subtractor_if #(.WIDTH(1)) if1 ();
    full_subtractor_if #(.WIDTH(4)) if4 ();

    full_subtractor #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    full_subtractor #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: plain integer subtraction; a negative result means a borrow out.
    function automatic int sub_ref(input int w, input int a, input int b, input int bin);
        int d;
        int bo;
        d  = a - b - bin;
        bo = 0;
        if (d < 0) begin
            bo = 1;
            d  = d + (1 << w);
        end
        return (bo << w) | d;
    endfunction

    // Expected {diff, borrow_out} for WIDTH=1, indexed by {a,b,borrow_in}.
    logic [1:0] tt_exp [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};

    int exp_dq1, exp_bq1, exp_ov1;
    int exp_dq4, exp_bq4, exp_ov4;

    initial begin
        int r;
        int a1, b1, c1, v1, a4, b4, c4, v4;
        logic [2:0] idx;

        if1.a = '0; if1.b = '0; if1.borrow_in = 1'b0; if1.in_valid = 1'b0;
        if4.a = '0; if4.b = '0; if4.borrow_in = 1'b0; if4.in_valid = 1'b0;

        // Combinational path with the clock stopped and reset held.
        if1.a = 1'b1; if1.b = 1'b0; if1.borrow_in = 1'b0;
        #1;
        check("noclk_diff", 32'(if1.diff), 32'd1);
        check("noclk_bo", 32'(if1.borrow_out), 32'd0);

        // Exhaustive truth table, 10 ns per vector.
        for (int i = 0; i < 8; i++) begin
            idx = 3'(i);
            if1.a = idx[2]; if1.b = idx[1]; if1.borrow_in = idx[0];
            #10;
            check($sformatf("tt%0d_diff", i), 32'(if1.diff), 32'(tt_exp[i][1]));
            check($sformatf("tt%0d_bo", i), 32'(if1.borrow_out), 32'(tt_exp[i][0]));
        end

        // WIDTH=4 directed vectors.
        if4.a = 4'd3; if4.b = 4'd5; if4.borrow_in = 1'b0;
        #10;
        check("w4_3m5_diff", 32'(if4.diff), 32'hE);
        check("w4_3m5_bo", 32'(if4.borrow_out), 32'd1);
        if4.a = 4'hF; if4.b = 4'h0; if4.borrow_in = 1'b1;
        #10;
        check("w4_Fm0m1_diff", 32'(if4.diff), 32'hE);
        check("w4_Fm0m1_bo", 32'(if4.borrow_out), 32'd0);
        if4.a = 4'h0; if4.b = 4'h0; if4.borrow_in = 1'b1;
        #10;
        check("w4_ripple_diff", 32'(if4.diff), 32'hF);
        check("w4_ripple_bo", 32'(if4.borrow_out), 32'd1);

        // Start the clock and apply reset.
        clk_run = 1'b1;
        rst = 1'b1;
        if1.in_valid = 1'b0; if4.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dq1", 32'(if1.diff_q), 32'd0);
        check("rst_bq1", 32'(if1.borrow_out_q), 32'd0);
        check("rst_ov1", 32'(if1.out_valid), 32'd0);
        check("rst_dq4", 32'(if4.diff_q), 32'd0);
        check("rst_ov4", 32'(if4.out_valid), 32'd0);

        // Registered capture: 0 - 1 - 1.
        @(negedge clk);
        rst = 1'b0;
        if1.in_valid = 1'b1; if1.a = 1'b0; if1.b = 1'b1; if1.borrow_in = 1'b1;
        @(posedge clk); #1;
        check("reg_dq", 32'(if1.diff_q), 32'd0);
        check("reg_bq", 32'(if1.borrow_out_q), 32'd1);
        check("reg_ov", 32'(if1.out_valid), 32'd1);

        // in_valid low: valid drops, data holds even though inputs change.
        @(negedge clk);
        if1.in_valid = 1'b0; if1.a = 1'b1; if1.b = 1'b0; if1.borrow_in = 1'b0;
        @(posedge clk); #1;
        check("hold_ov", 32'(if1.out_valid), 32'd0);
        check("hold_dq", 32'(if1.diff_q), 32'd0);
        check("hold_bq", 32'(if1.borrow_out_q), 32'd1);
        check("hold_comb_diff", 32'(if1.diff), 32'd1);

        // Reset beats in_valid.
        @(negedge clk);
        rst = 1'b1;
        if1.in_valid = 1'b1; if1.a = 1'b1; if1.b = 1'b0; if1.borrow_in = 1'b0;
        @(posedge clk); #1;
        check("rstwin_dq", 32'(if1.diff_q), 32'd0);
        check("rstwin_bq", 32'(if1.borrow_out_q), 32'd0);
        check("rstwin_ov", 32'(if1.out_valid), 32'd0);
        check("rstwin_comb", 32'(if1.diff), 32'd1);

        // Randomized stream on both widths against the reference model.
        exp_dq1 = 0; exp_bq1 = 0; exp_ov1 = 0;
        exp_dq4 = 0; exp_bq4 = 0; exp_ov4 = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            rst = (n == 0) || ($urandom_range(0, 19) == 0);
            a1 = int'($urandom_range(0, 1));  b1 = int'($urandom_range(0, 1));
            c1 = int'($urandom_range(0, 1));  v1 = int'($urandom_range(0, 1));
            a4 = int'($urandom_range(0, 15)); b4 = int'($urandom_range(0, 15));
            c4 = int'($urandom_range(0, 1));  v4 = int'($urandom_range(0, 1));
            if1.a = 1'(a1); if1.b = 1'(b1); if1.borrow_in = 1'(c1); if1.in_valid = 1'(v1);
            if4.a = 4'(a4); if4.b = 4'(b4); if4.borrow_in = 1'(c4); if4.in_valid = 1'(v4);
            #1;
            r = sub_ref(1, a1, b1, c1);
            check("rnd1_comb", 32'({if1.borrow_out, if1.diff}), 32'(r));
            r = sub_ref(4, a4, b4, c4);
            check("rnd4_comb", 32'({if4.borrow_out, if4.diff}), 32'(r));

            @(posedge clk);
            if (rst) begin
                exp_dq1 = 0; exp_bq1 = 0; exp_ov1 = 0;
                exp_dq4 = 0; exp_bq4 = 0; exp_ov4 = 0;
            end else begin
                exp_ov1 = v1;
                if (v1 != 0) begin
                    r = sub_ref(1, a1, b1, c1);
                    exp_dq1 = r & 1; exp_bq1 = r >> 1;
                end
                exp_ov4 = v4;
                if (v4 != 0) begin
                    r = sub_ref(4, a4, b4, c4);
                    exp_dq4 = r & 15; exp_bq4 = r >> 4;
                end
            end
            #1;
            check("rnd1_reg", 32'({if1.out_valid, if1.borrow_out_q, if1.diff_q}),
                  32'((exp_ov1 << 2) | (exp_bq1 << 1) | exp_dq1));
            check("rnd4_reg", 32'({if4.out_valid, if4.borrow_out_q, if4.diff_q}),
                  32'((exp_ov4 << 5) | (exp_bq4 << 4) | exp_dq4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
